// File: rtl/input_mem_ctrl.sv
// Load/read sequencer for the banked input feature-map BRAM: round-robin stream scatter and lockstep reads.
// Define INPUT_MEM_CTRL_PERF_EN to add the o_stall_cnt load-stall counter output.
module input_mem_ctrl #(
    parameter int INPUT_BRAM_NUM           = 4,
    parameter int INPUT_BRAM_ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH               = 32,
    parameter int RD_LATENCY               = 2
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic                                i_load_start,
    input  logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] i_load_len,
    input  logic                                i_s_valid,
    input  logic [DATA_WIDTH-1:0]               i_s_data,
    output logic                                o_s_ready,
    input  logic                                i_rd_start,
    input  logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] i_rd_base,
    input  logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] i_rd_count,
    output logic                                o_enable   [INPUT_BRAM_NUM],
    output logic                                o_wenable  [INPUT_BRAM_NUM],
    output logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] o_waddress [INPUT_BRAM_NUM],
    output logic [DATA_WIDTH-1:0]               o_bram_data,
    output logic                                o_renable  [INPUT_BRAM_NUM],
    output logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] o_raddress [INPUT_BRAM_NUM],
    output logic                                o_rd_valid,
    output logic                                o_rd_last,
    output logic                                o_busy,
    output logic                                o_done
`ifdef INPUT_MEM_CTRL_PERF_EN
    ,
    output logic [31:0]                         o_stall_cnt
`endif
);
    localparam int AW = INPUT_BRAM_ADDRESS_WIDTH;
    localparam int LG = $clog2(INPUT_BRAM_NUM);
    localparam int CW = AW + LG;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN, S_DONE} state_t;
    state_t state, state_n;

    logic [CW-1:0]         k;
    logic [CW-1:0]         load_last;
    logic [AW-1:0]         len_q, base_q, cnt_q, rd_idx;
    logic [LG-1:0]         bank;
    logic                  hs, issue, issue_last;
    logic [RD_LATENCY:1]   vld_q, last_q;
    logic [RD_LATENCY:0]   vld_pipe, last_pipe;

    // Word counter is one bank-index wider than an address so a full-depth load fits.
    assign load_last  = {len_q, {LG{1'b0}}} - CW'(1);
    assign bank       = k[LG-1:0];
    assign hs         = (state == S_LOAD) && i_s_valid;
    assign issue      = (state == S_READ);
    assign issue_last = issue && (rd_idx == cnt_q - AW'(1));

    // Stage 0 is the issue strobe itself; stage RD_LATENCY lines up with doutb.
    assign vld_pipe   = {vld_q, issue};
    assign last_pipe  = {last_q, issue_last};

    assign o_s_ready  = (state == S_LOAD);
    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);
    assign o_rd_valid = vld_pipe[RD_LATENCY];
    assign o_rd_last  = last_pipe[RD_LATENCY];

    always_comb begin
        for (int b = 0; b < INPUT_BRAM_NUM; b++) begin
            o_enable[b]   = o_wenable[b];
            o_renable[b]  = issue;
            o_raddress[b] = base_q + rd_idx;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (i_load_start)
                    state_n = (i_load_len == '0) ? S_DONE : S_LOAD;
                else if (i_rd_start)
                    state_n = (i_rd_count == '0) ? S_DONE : S_READ;
            end
            S_LOAD:  if (hs && (k == load_last)) state_n = S_DRAIN;
            S_READ:  if (issue_last) state_n = S_DRAIN;
            // Load reaches here with an empty pipe, so it only spends the final-write cycle.
            S_DRAIN: if (vld_pipe[RD_LATENCY-1:0] == '0) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= S_IDLE;
            k           <= '0;
            len_q       <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            rd_idx      <= '0;
            vld_q       <= '0;
            last_q      <= '0;
            o_bram_data <= '0;
            for (int b = 0; b < INPUT_BRAM_NUM; b++) begin
                o_wenable[b]  <= 1'b0;
                o_waddress[b] <= '0;
            end
        end else begin
            state  <= state_n;
            vld_q  <= vld_pipe[RD_LATENCY-1:0];
            last_q <= last_pipe[RD_LATENCY-1:0];

            if (state == S_IDLE) begin
                k <= '0;
                if (i_load_start) begin
                    len_q <= i_load_len;
                end else if (i_rd_start) begin
                    base_q <= i_rd_base;
                    cnt_q  <= i_rd_count;
                    rd_idx <= '0;
                end
            end else if (hs) begin
                k <= k + CW'(1);
            end

            if (issue) rd_idx <= rd_idx + AW'(1);

            for (int b = 0; b < INPUT_BRAM_NUM; b++) begin
                o_wenable[b] <= hs && (bank == LG'(b));
                if (hs && (bank == LG'(b))) o_waddress[b] <= k[CW-1:LG];
            end
            if (hs) o_bram_data <= i_s_data;
        end
    end

`ifdef INPUT_MEM_CTRL_PERF_EN
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            o_stall_cnt <= '0;
        else if ((state == S_IDLE) && i_load_start)
            o_stall_cnt <= '0;
        else if ((state == S_LOAD) && !i_s_valid && (o_stall_cnt != '1))
            o_stall_cnt <= o_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_input_mem_ctrl.sv
// Bench for input_mem_ctrl: per-cycle timeline model of load/read transactions plus literal pins.
module tb_input_mem_ctrl;
    localparam int NB = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int NC = 1024;

    logic clk = 1'b0;
    logic i_reset, i_load_start, i_s_valid, i_rd_start;
    logic [AW-1:0] i_load_len, i_rd_base, i_rd_count;
    logic [DW-1:0] i_s_data;
    logic o_s_ready, o_rd_valid, o_rd_last, o_busy, o_done;
    logic o_enable [NB];
    logic o_wenable [NB];
    logic [AW-1:0] o_waddress [NB];
    logic [DW-1:0] o_bram_data;
    logic o_renable [NB];
    logic [AW-1:0] o_raddress [NB];
`ifdef INPUT_MEM_CTRL_PERF_EN
    logic [31:0] o_stall_cnt;
`endif

    input_mem_ctrl #(.INPUT_BRAM_NUM(NB), .INPUT_BRAM_ADDRESS_WIDTH(AW),
                     .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
        .i_clock(clk), .i_reset(i_reset),
        .i_load_start(i_load_start), .i_load_len(i_load_len),
        .i_s_valid(i_s_valid), .i_s_data(i_s_data), .o_s_ready(o_s_ready),
        .i_rd_start(i_rd_start), .i_rd_base(i_rd_base), .i_rd_count(i_rd_count),
        .o_enable(o_enable), .o_wenable(o_wenable), .o_waddress(o_waddress),
        .o_bram_data(o_bram_data), .o_renable(o_renable), .o_raddress(o_raddress),
        .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last), .o_busy(o_busy), .o_done(o_done)
`ifdef INPUT_MEM_CTRL_PERF_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Expected outputs per cycle; default is the idle picture.
    bit e_ready [NC], e_busy [NC], e_done [NC], e_rvalid [NC], e_rlast [NC], e_ren [NC];
    int e_wbank [NC], e_waddr [NC], e_wdata [NC], e_raddr [NC];

    typedef struct { int bank; int addr; int data; } wr_t;
    wr_t wq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void clear_from(input int t0);
        for (int t = t0; t < NC; t++) begin
            e_ready[t] = 0; e_busy[t] = 0; e_done[t] = 0; e_rvalid[t] = 0;
            e_rlast[t] = 0; e_ren[t] = 0; e_wbank[t] = -1; e_waddr[t] = 0;
            e_wdata[t] = 0; e_raddr[t] = 0;
        end
    endfunction

    // Load: ready in every load cycle, each accepted word k lands one cycle later in
    // bank k%NB at address k/NB; done two cycles after the last accept.
    function automatic void fill_load(input int s, input int len, input bit gaps, input int dbase);
        int t, k, j;
        if (len == 0) begin
            e_busy[s+1] = 1; e_done[s+1] = 1;
            return;
        end
        t = s + 1; k = 0; j = 0;
        while (k < len * NB) begin
            e_ready[t] = 1; e_busy[t] = 1;
            if (!gaps || (j % 2 == 0)) begin
                e_wbank[t+1] = k % NB; e_waddr[t+1] = k / NB; e_wdata[t+1] = dbase + k;
                k++;
            end
            j++; t++;
        end
        e_busy[t] = 1; e_busy[t+1] = 1; e_done[t+1] = 1;
    endfunction

    // Read: issues i=0..count-1 on consecutive cycles from s+1, data valid L later,
    // done the cycle after the last valid beat.
    function automatic void fill_read(input int s, input int base, input int count);
        if (count == 0) begin
            e_busy[s+1] = 1; e_done[s+1] = 1;
            return;
        end
        for (int i = 0; i < count; i++) begin
            e_ren[s+1+i] = 1; e_raddr[s+1+i] = (base + i) & 'hFFFF;
            e_rvalid[s+1+i+L] = 1;
        end
        for (int t = s + 1; t <= s + count + L + 1; t++) e_busy[t] = 1;
        e_rlast[s+count+L] = 1;
        e_done[s+count+L+1] = 1;
    endfunction

    always @(negedge clk) begin
        if (cyc < NC) begin
            int c;
            logic [NB-1:0] aen, awen, aren, xen;
            c = cyc;
            xen = '0;
            if (e_wbank[c] >= 0) xen[e_wbank[c]] = 1'b1;
            for (int b = 0; b < NB; b++) begin
                aen[b] = o_enable[b]; awen[b] = o_wenable[b]; aren[b] = o_renable[b];
            end
            chk("s_ready", o_s_ready, e_ready[c]);
            chk("busy", o_busy, e_busy[c]);
            chk("done", o_done, e_done[c]);
            chk("rd_valid", o_rd_valid, e_rvalid[c]);
            chk("rd_last", o_rd_last, e_rlast[c]);
            chk("enable", aen, xen);
            chk("wenable", awen, xen);
            chk("renable", aren, e_ren[c] ? {NB{1'b1}} : {NB{1'b0}});
            if (e_wbank[c] >= 0) begin
                chk("waddr", o_waddress[e_wbank[c]], e_waddr[c]);
                chk("wdata", o_bram_data, e_wdata[c]);
            end
            if (e_ren[c])
                for (int b = 0; b < NB; b++) chk("raddr", o_raddress[b], e_raddr[c]);
        end
    end

    always @(negedge clk)
        if (i_reset === 1'b1)
            for (int b = 0; b < NB; b++)
                if (o_wenable[b]) wq.push_back('{b, int'(o_waddress[b]), int'(o_bram_data)});

    task automatic run_load(input int len, input bit gaps, input int dbase,
                            input bit rd_same, input bit rd_mid, input int stop_after);
        int s, k, j;
        bit v;
        @(posedge clk); #1;
        s = cyc;
        fill_load(s, len, gaps, dbase);
        i_load_start = 1'b1; i_load_len = AW'(len); i_rd_start = rd_same;
        i_rd_base = 16'h0100; i_rd_count = 16'd5;
        @(posedge clk); #1;
        i_load_start = 1'b0; i_rd_start = 1'b0;
        k = 0; j = 0;
        while (k < len * NB) begin
            if (k == stop_after) begin
                clear_from(cyc);
                i_reset = 1'b0; i_s_valid = 1'b0;
                return;
            end
            v = !gaps || (j % 2 == 0);
            i_s_valid = v; i_s_data = DW'(dbase + k);
            i_rd_start = rd_mid && (j == 1);
            if (v) k++;
            j++;
            @(posedge clk); #1;
        end
        i_s_valid = 1'b0; i_rd_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_read(input int base, input int count, output int a0, output int a2,
                            output int lat, output int nval, output int nren,
                            output int dgap, output int dstart);
        int s, fr, fv, lc, dc;
        @(posedge clk); #1;
        s = cyc;
        fill_read(s, base, count);
        i_rd_start = 1'b1; i_rd_base = AW'(base); i_rd_count = AW'(count);
        @(posedge clk); #1;
        i_rd_start = 1'b0;
        fr = -1; fv = -1; lc = -1; dc = -1; a0 = -1; a2 = -1; nval = 0; nren = 0;
        for (int n = 0; n < count + L + 3; n++) begin
            @(negedge clk);
            if (o_renable[0]) begin
                nren++;
                if (fr < 0) begin fr = cyc; a0 = int'(o_raddress[0]); end
                else if (cyc == fr + 2) a2 = int'(o_raddress[1]);
            end
            if (o_rd_valid) begin nval++; if (fv < 0) fv = cyc; end
            if (o_rd_last) lc = cyc;
            if (o_done) dc = cyc;
        end
        lat = fv - fr; dgap = dc - lc; dstart = dc - s;
        @(posedge clk); #1;
    endtask

    initial begin
        int a0, a2, lat, nval, nren, dgap, dstart;
        clear_from(0);
        i_reset = 1'b0; i_load_start = 1'b0; i_rd_start = 1'b0; i_s_valid = 1'b0;
        i_load_len = '0; i_rd_base = '0; i_rd_count = '0; i_s_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_bram_data", o_bram_data, 0);
        chk("reset_raddr", o_raddress[2], 0);
        @(posedge clk); #1;
        i_reset = 1'b1;

        // Reset after 5 of 12 handshakes, then a fresh len=1 load.
        run_load(3, 0, 'h10, 0, 0, 5);
        @(negedge clk);
        chk("midrst_bram_data", o_bram_data, 0);
        chk("midrst_waddr0", o_waddress[0], 0);
        chk("midrst_ready", o_s_ready, 0);
        @(posedge clk); #1;
        i_reset = 1'b1;
        run_load(1, 0, 'h20, 0, 0, -1);

        // Back-to-back len=2 load.
        wq.delete();
        run_load(2, 0, 'hA0, 0, 0, -1);
        chk("t2_nwrites", wq.size(), 8);
        if (wq.size() == 8) begin
            chk("t2_w1_bank", wq[1].bank, 1);
            chk("t2_w1_addr", wq[1].addr, 0);
            chk("t2_w4_bank", wq[4].bank, 0);
            chk("t2_w4_addr", wq[4].addr, 1);
            chk("t2_w7_bank", wq[7].bank, 3);
            chk("t2_w7_data", wq[7].data, 'hA7);
        end
`ifdef INPUT_MEM_CTRL_PERF_EN
        chk("t2_stall", o_stall_cnt, 0);
`endif

        // Gapped len=1 load.
        wq.delete();
        run_load(1, 1, 'hC0, 0, 0, -1);
        chk("t3_nwrites", wq.size(), 4);
`ifdef INPUT_MEM_CTRL_PERF_EN
        chk("t3_stall", o_stall_cnt, 3);
`endif

        // Read across the address wrap.
        run_read('hFFFE, 3, a0, a2, lat, nval, nren, dgap, dstart);
        chk("t4_addr_first", a0, 'hFFFE);
        chk("t4_addr_third", a2, 'h0000);
        chk("t4_valid_latency", lat, 2);
        chk("t4_nvalid", nval, 3);
        chk("t4_done_after_last", dgap, 1);

        // Zero-length read and load.
        run_read('h0010, 0, a0, a2, lat, nval, nren, dgap, dstart);
        chk("t5_nren", nren, 0);
        chk("t5_done_delay", dstart, 1);
        run_load(0, 0, 'h00, 0, 0, -1);

        // Start collisions: simultaneous starts, then a read start during a load.
        run_load(1, 0, 'hD0, 1, 0, -1);
        run_load(2, 0, 'hE0, 0, 1, -1);

        // Plain read after everything else.
        run_read('h0040, 5, a0, a2, lat, nval, nren, dgap, dstart);
        chk("t7_nvalid", nval, 5);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
